// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Function : Sequences one ALU operation: operand load, timed execute,
//            low/high result capture, done pulse; rejects illegal opcodes.
// Revision : 1.0
// ============================================================================
module alu_seq_ctrl #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [4:0]  op,
    input  logic [31:0] ra_data,
    input  logic [31:0] rb_data,
    input  logic [63:0] z_in,
    output logic [31:0] alu_y,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_opcode,
    output logic [31:0] zlo,
    output logic [31:0] zhi,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_Y = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_CAP_LO = 3'd3;
    localparam logic [2:0] S_CAP_HI = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
    localparam logic [4:0] OP_NEG = 5'b10001;
    localparam logic [4:0] OP_NOT = 5'b10010;

    localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [3:0]  r_cnt;
    logic [4:0]  r_op;
    logic [31:0] r_rb;
    logic        r_illegal;
    logic        w_legal;
    logic        w_accept;
    logic        w_reject;

    always_comb begin
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011,
            OP_MUL, OP_DIV, OP_NEG, OP_NOT: w_legal = 1'b1;
            default:                        w_legal = 1'b0;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && start && w_legal;
    assign w_reject = (r_state == S_IDLE) && start && !w_legal;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_LOAD_Y;
            S_LOAD_Y: w_next = S_EXEC;
            S_EXEC:   if (r_cnt == LAT_LAST) w_next = S_CAP_LO;
            // Only the double-word results carry a meaningful high half
            S_CAP_LO: w_next = ((r_op == OP_MUL) || (r_op == OP_DIV)) ? S_CAP_HI : S_DONE;
            S_CAP_HI: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    assign illegal = r_illegal;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt      <= 4'd0;
            r_op       <= 5'd0;
            r_rb       <= 32'd0;
            r_illegal  <= 1'b0;
            alu_y      <= 32'd0;
            alu_b      <= 32'd0;
            alu_opcode <= 5'd0;
            zlo        <= 32'd0;
            zhi        <= 32'd0;
        end else begin
            r_illegal <= w_reject;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= op;
                        r_rb  <= rb_data;
                        // Unary ops take their operand on the B side; Y is zeroed
                        alu_y <= ((op == OP_NEG) || (op == OP_NOT)) ? 32'd0 : ra_data;
                    end
                end
                S_LOAD_Y: begin
                    alu_b      <= r_rb;
                    alu_opcode <= r_op;
                    r_cnt      <= 4'd0;
                end
                S_EXEC:   r_cnt <= r_cnt + 4'd1;
                S_CAP_LO: zlo   <= z_in[31:0];
                S_CAP_HI: zhi   <= z_in[63:32];
                default:  ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter: ALU_LAT, default 1, number of cycles the ALU result needs to settle after operands and opcode are driven; legal range 1-15.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: clr  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to issue one ALU operation; sampled only in IDLE.
REQ-005 Port: op  input  5  ALU opcode to issue.
REQ-006 Port: ra_data  input  32  first operand, destined for the Y side.
REQ-007 Port: rb_data  input  32  second operand, destined for the B side.
REQ-008 Port: z_in  input  64  ALU result returned from the ALU.
REQ-009 Port: alu_y  output  32  Y operand driven to the ALU.
REQ-010 Port: alu_b  output  32  B operand driven to the ALU.
REQ-011 Port: alu_opcode  output  5  opcode driven to the ALU.
REQ-012 Port: zlo  output  32  captured low result word.
REQ-013 Port: zhi  output  32  captured high result word.
REQ-014 Port: busy  output  1  high in every state except IDLE.
REQ-015 Port: done  output  1  one-cycle pulse on completion.
REQ-016 Port: illegal  output  1  one-cycle pulse when a rejected opcode is presented with start.

Function
REQ-017 The following opcodes SHALL be legal: 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shra, 01001 shl, 01010 ror, 01011 rol, 01111 mul, 10000 div, 10001 neg, 10010 not.
REQ-018 All other opcodes SHALL be illegal.
REQ-019 FSM states SHALL be IDLE, LOAD_Y, EXEC, CAP_LO, CAP_HI, DONE.
REQ-020 IDLE with start=1 and a legal op (cycle N) SHALL latch op, ra_data and rb_data, and move to LOAD_Y.
REQ-021 IDLE with start=1 and an illegal op SHALL pulse illegal at N+1, remain in IDLE, and leave all other outputs unchanged.
REQ-022 LOAD_Y SHALL drive alu_y from the latched ra; for neg and not, alu_y SHALL be driven to 0 instead.
REQ-023 On entry to EXEC, alu_b SHALL be driven with the latched rb and alu_opcode with the latched op.
REQ-024 EXEC SHALL last exactly ALU_LAT cycles, timed by an internal 4-bit counter.
REQ-025 CAP_LO SHALL load zlo from z_in[31:0].
REQ-026 After CAP_LO, mul and div SHALL go to CAP_HI, which loads zhi from z_in[63:32]; all other ops SHALL skip CAP_HI, and zhi SHALL hold its previous value.
REQ-027 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-028 With ALU_LAT=1, done SHALL be high in cycle N+4 for single-word ops and N+5 for mul/div.
REQ-029 start SHALL be ignored while busy=1; inputs changing mid-operation SHALL NOT affect the latched op or operands.
REQ-030 start SHALL be accepted in the IDLE cycle that immediately follows DONE, giving back-to-back operation.
REQ-031 alu_y, alu_b and alu_opcode SHALL hold their last values in IDLE until the next operation is issued.
REQ-032 z_in SHALL be sampled only in CAP_LO and CAP_HI.

Reset
REQ-033 clr=0 SHALL force, asynchronously, state=IDLE, the EXEC counter to 0, and alu_y, alu_b, zlo, zhi to 0, alu_opcode to 00000, and busy, done, illegal to 0.
REQ-034 clr asserted mid-operation SHALL abort the operation with no done pulse and no further zlo/zhi update.
REQ-035 After clr is released, the first rising edge SHALL be able to accept start.

Verification
REQ-036 add: op=00011, ra=0x14, rb=0x12, ALU model returns 0x26 -> alu_y=0x14, alu_b=0x12, zlo=0x26, zhi unchanged, done at N+4.
REQ-037 mul: op=01111, ra=4, rb=12, model z_in=0x0000_0000_0000_0030 -> zlo=0x30, zhi=0, done at N+5; repeat with ALU_LAT=3 -> done at N+7.
REQ-038 neg: op=10001, ra=5, rb=5 -> alu_y=0, alu_b=5; model returns 0xFFFFFFFB -> zlo=0xFFFFFFFB.
REQ-039 illegal: op=00000 with start -> illegal pulses once, busy stays 0, no done, zlo/zhi unchanged.
REQ-040 start pulsed during EXEC with op=00101 -> ignored; the original op completes and exactly one done is seen.
REQ-041 clr driven low in EXEC, between clock edges -> outputs zero immediately, no done; a fresh add after release completes normally.
